// File: rtl/dm_ext.sv
// Byte-addressable 32-bit data memory with lane-masked stores, extended loads,
// a post-reset zero-fill sweep and optional store logging.
module dm_ext #(
   parameter int unsigned ADDR_W = 10,
   parameter bit          LOG_EN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] PC,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic        rvalid,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   typedef enum logic {CLEAR, RUN} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic                ready_q, ready_d;
   logic                rvalid_q, rvalid_d;
   logic                err_q, err_d;
   logic [31:0]         rdata_q, rdata_d;

   logic [31:0]         mem [DEPTH];

   logic [ADDR_W-1:0]   word_idx_c;
   logic                accept_c;
   logic                misalign_c;
   logic                store_ok_c;
   logic [3:0]          lane_en_c;
   logic [31:0]         lane_data_c;
   logic [31:0]         rd_word_c;
   logic [31:0]         shifted_c;
   logic [31:0]         load_val_c;
   logic [31:0]         merged_c;
   logic                mem_we_c;
   logic [ADDR_W-1:0]   mem_idx_c;
   logic [31:0]         mem_wdata_c;

   // Access decode: alignment, lane enables, merged store word and extended load value
   always_comb begin
      word_idx_c  = addr[ADDR_W+1:2];
      accept_c    = req & ready_q;
      misalign_c  = (size == 2'b11) |
                    ((size == 2'b01) & addr[0]) |
                    ((size == 2'b10) & (addr[1:0] != 2'b00));
      store_ok_c  = accept_c & we & ~misalign_c;
      rd_word_c   = mem[word_idx_c];
      lane_en_c   = 4'b0000;
      lane_data_c = wdata;
      case (size)
         2'b00: begin
            lane_en_c   = 4'b0001 << addr[1:0];
            lane_data_c = {4{wdata[7:0]}};
         end
         2'b01: begin
            lane_en_c   = addr[1] ? 4'b1100 : 4'b0011;
            lane_data_c = {2{wdata[15:0]}};
         end
         default: lane_en_c = 4'b1111;
      endcase
      for (int i = 0; i < 4; i++) begin
         merged_c[8*i +: 8] = lane_en_c[i] ? lane_data_c[8*i +: 8] : rd_word_c[8*i +: 8];
      end
      shifted_c = rd_word_c >> {addr[1:0], 3'b000};
      case (size)
         2'b00:   load_val_c = sign_ext ? {{24{shifted_c[7]}}, shifted_c[7:0]}
                                        : {24'h0, shifted_c[7:0]};
         2'b01:   load_val_c = sign_ext ? {{16{shifted_c[15]}}, shifted_c[15:0]}
                                        : {16'h0, shifted_c[15:0]};
         default: load_val_c = rd_word_c;
      endcase
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      rvalid_d    = 1'b0;
      err_d       = 1'b0;
      rdata_d     = rdata_q;
      mem_we_c    = 1'b0;
      mem_idx_c   = word_idx_c;
      mem_wdata_c = merged_c;
      case (state_q)
         CLEAR: begin
            mem_we_c    = 1'b1;
            mem_idx_c   = idx_q;
            mem_wdata_c = 32'h0;
            idx_d       = idx_q + ADDR_W'(1);
            if (idx_q == ADDR_W'(DEPTH - 1)) begin
               state_d = RUN;
               idx_d   = '0;
            end
         end
         RUN: begin
            if (accept_c) begin
               if (misalign_c) begin
                  rvalid_d = 1'b1;
                  err_d    = 1'b1;
                  rdata_d  = 32'h0;
               end else if (we) begin
                  mem_we_c = 1'b1;
               end else begin
                  rvalid_d = 1'b1;
                  rdata_d  = load_val_c;
               end
            end
         end
         default: state_d = CLEAR;
      endcase
      ready_d = (state_d == RUN);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= CLEAR;
         idx_q    <= '0;
         ready_q  <= 1'b0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= 32'h0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         ready_q  <= ready_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   // Storage array has no reset; the CLEAR sweep zero-fills it
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         mem[mem_idx_c] <= mem_wdata_c;
      end
      if (LOG_EN && store_ok_c) begin
         $display("@%08h: *%08h <= %08h", PC, {addr[31:2], 2'b00}, merged_c);
      end
   end

   assign ready  = ready_q;
   assign rvalid = rvalid_q;
   assign err    = err_q;
   assign rdata  = rdata_q;

endmodule

// File: tb/tb_dm_ext.sv
// Self-checking bench for dm_ext (ADDR_W=4): directed vector table, reset/clear
// sequences and randomized traffic against a byte-level memory model.
module tb_dm_ext;

   localparam int unsigned AW    = 4;
   localparam int unsigned WORDS = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] addr;
   logic [31:0] PC;
   logic [31:0] wdata;
   logic        ready;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;

   int checks = 0;
   int errors = 0;

   logic [31:0] m [WORDS];
   logic [31:0] last_rd;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sx;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rv;
      logic        er;
      logic [31:0] rd;
   } vec_t;

   vec_t tbl [18];

   dm_ext #(.ADDR_W(AW), .LOG_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
      .sign_ext(sign_ext), .addr(addr), .PC(PC), .wdata(wdata),
      .ready(ready), .rvalid(rvalid), .rdata(rdata), .err(err)
   );

   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%08h required=%08h", name, act, exp);
      end
   endtask

   // Reference: memory as bytes, alignment as address modulo access size
   function automatic void model(input logic w, input logic [1:0] sz, input logic sx,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 output logic rv, output logic er, output logic [31:0] rd);
      int n, off, wi;
      logic [31:0] word, val;
      n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      off = int'(a % 32'd4);
      wi  = int'((a / 32'd4) % 32'(WORDS));
      rv  = 1'b0;
      er  = 1'b0;
      rd  = 32'h0;
      if (sz == 2'd3 || (off % n) != 0) begin
         rv = 1'b1;
         er = 1'b1;
      end else if (w) begin
         word = m[wi];
         for (int b = 0; b < n; b++) word[8*(off+b) +: 8] = wd[8*b +: 8];
         m[wi] = word;
      end else begin
         rv  = 1'b1;
         val = m[wi] >> (8 * off);
         if (n < 4) begin
            val = val & ((32'h1 << (8 * n)) - 32'h1);
            if (sx && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
         end
         rd = val;
      end
   endfunction

   // One request cycle; expected rdata is the held value when no response is due
   task automatic xact(input logic r, input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic erv, input logic eer, input logic [31:0] erd,
                       input string tag);
      req = r; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
      PC  = PC + 32'd4;
      cycle();
      check({tag, " rvalid"}, 32'(rvalid), 32'(erv));
      check({tag, " err"}, 32'(err), 32'(eer));
      if (erv) last_rd = erd;
      check({tag, " rdata"}, rdata, last_rd);
   endtask

   task automatic count_clear(input string tag);
      int cnt;
      cnt = 0;
      while (!ready && cnt < 100) begin
         cycle();
         cnt++;
      end
      check({tag, " clear cycles"}, 32'(cnt), 32'd16);
      cycle();
      check({tag, " ready stays high"}, 32'(ready), 32'd1);
      for (int i = 0; i < int'(WORDS); i++) m[i] = 32'h0;
      last_rd = 32'h0;
   endtask

   task automatic load_all_zero(input string tag);
      for (int i = 0; i < int'(WORDS); i++) begin
         xact(1'b1, 1'b0, 2'b10, 1'b0, 32'(4 * i), 32'h0, 1'b1, 1'b0, 32'h0, tag);
      end
      req = 1'b0;
   endtask

   initial begin
      logic        rv, er;
      logic [31:0] rd;
      reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
      addr = 32'h0; PC = 32'h1000; wdata = 32'h0; last_rd = 32'h0;

      // Reset state, asynchronous with respect to clk
      #2;
      check("reset ready", 32'(ready), 32'd0);
      check("reset rvalid", 32'(rvalid), 32'd0);
      check("reset err", 32'(err), 32'd0);
      check("reset rdata", rdata, 32'h0);
      cycle();
      cycle();
      reset = 1'b1;
      count_clear("initial");
      load_all_zero("initial load zero");

      tbl[0]  = '{1'b1, 2'b10, 1'b0, 32'h08, 32'h11223344, 1'b0, 1'b0, 32'h0};
      tbl[1]  = '{1'b1, 2'b00, 1'b0, 32'h0A, 32'h000000AB, 1'b0, 1'b0, 32'h0};
      tbl[2]  = '{1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        1'b1, 1'b0, 32'h11AB3344};
      tbl[3]  = '{1'b1, 2'b10, 1'b0, 32'h00, 32'h80FF7F01, 1'b0, 1'b0, 32'h0};
      tbl[4]  = '{1'b0, 2'b00, 1'b1, 32'h02, 32'h0,        1'b1, 1'b0, 32'hFFFFFFFF};
      tbl[5]  = '{1'b0, 2'b00, 1'b0, 32'h03, 32'h0,        1'b1, 1'b0, 32'h00000080};
      tbl[6]  = '{1'b0, 2'b01, 1'b1, 32'h02, 32'h0,        1'b1, 1'b0, 32'hFFFF80FF};
      tbl[7]  = '{1'b0, 2'b01, 1'b0, 32'h00, 32'h0,        1'b1, 1'b0, 32'h00007F01};
      tbl[8]  = '{1'b1, 2'b10, 1'b0, 32'h06, 32'hDEADBEEF, 1'b1, 1'b1, 32'h0};
      tbl[9]  = '{1'b0, 2'b01, 1'b0, 32'h03, 32'h0,        1'b1, 1'b1, 32'h0};
      tbl[10] = '{1'b0, 2'b11, 1'b0, 32'h04, 32'h0,        1'b1, 1'b1, 32'h0};
      tbl[11] = '{1'b1, 2'b11, 1'b0, 32'h08, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0};
      tbl[12] = '{1'b0, 2'b10, 1'b0, 32'h04, 32'h0,        1'b1, 1'b0, 32'h0};
      tbl[13] = '{1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        1'b1, 1'b0, 32'h11AB3344};
      tbl[14] = '{1'b1, 2'b10, 1'b0, 32'h40, 32'h00000005, 1'b0, 1'b0, 32'h0};
      tbl[15] = '{1'b0, 2'b10, 1'b0, 32'h00, 32'h0,        1'b1, 1'b0, 32'h00000005};
      tbl[16] = '{1'b1, 2'b01, 1'b0, 32'h42, 32'h0000BEEF, 1'b0, 1'b0, 32'h0};
      tbl[17] = '{1'b0, 2'b00, 1'b1, 32'h43, 32'h0,        1'b1, 1'b0, 32'hFFFFFFBE};

      // Back-to-back directed vectors; the model is kept in step for later phases
      for (int i = 0; i < 18; i++) begin
         model(tbl[i].we, tbl[i].size, tbl[i].sx, tbl[i].addr, tbl[i].wdata, rv, er, rd);
         xact(1'b1, tbl[i].we, tbl[i].size, tbl[i].sx, tbl[i].addr, tbl[i].wdata,
              tbl[i].rv, tbl[i].er, tbl[i].rd, $sformatf("vec%0d", i));
      end
      req = 1'b0;
      cycle();

      // Randomized traffic with idle cycles, wrapping addresses and illegal sizes
      for (int i = 0; i < 400; i++) begin
         logic        r, w, sx;
         logic [1:0]  sz;
         logic [31:0] a, wd;
         r  = ($urandom_range(0, 3) != 0);
         w  = $urandom_range(0, 1) != 0;
         sz = 2'($urandom_range(0, 3));
         sx = $urandom_range(0, 1) != 0;
         a  = $urandom & 32'h0000_01FF;
         if ($urandom_range(0, 1) != 0) a = a & ~32'h3;
         wd = $urandom;
         if (r) model(w, sz, sx, a, wd, rv, er, rd);
         else begin rv = 1'b0; er = 1'b0; rd = 32'h0; end
         xact(r, w, sz, sx, a, wd, rv, er, rd, $sformatf("rand%0d", i));
      end
      req = 1'b0;
      cycle();

      // Reset in the middle of the clear sweep restarts the full count
      reset = 1'b0;
      cycle();
      reset = 1'b1;
      for (int i = 0; i < 7; i++) cycle();
      check("mid-clear ready low", 32'(ready), 32'd0);
      reset = 1'b0;
      #2;
      check("mid-clear rvalid", 32'(rvalid), 32'd0);
      cycle();
      reset = 1'b1;
      count_clear("mid-clear restart");

      // Reset on a load-acceptance edge drops the response
      xact(1'b1, 1'b1, 2'b10, 1'b0, 32'h0C, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, "pre-reset store");
      xact(1'b1, 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 1'b1, 1'b0, 32'hCAFEF00D, "pre-reset load");
      addr = 32'h0C;
      @(posedge clk);
      reset = 1'b0;
      #1;
      req = 1'b0;
      check("accept-edge reset rvalid", 32'(rvalid), 32'd0);
      check("accept-edge reset rdata", rdata, 32'h0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("in-reset rvalid", 32'(rvalid), 32'd0);
         check("in-reset ready", 32'(ready), 32'd0);
      end
      reset = 1'b1;
      count_clear("accept-edge restart");
      load_all_zero("post-reset load zero");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
